multiplicador_secuencial: RTL and testbench

MULTIPLICADOR_SECUENCIAL -- requirements
Module: multiplicador_secuencial

---
 rtl/multiplicador_secuencial.sv | 125 ++++++++++++
 tb/tb_multiplicador_secuencial.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/multiplicador_secuencial.sv
// Sequential 16x16 unsigned multiplier (shift-and-add, one multiplier bit per
// clock, LSB first) that writes its product back into a register file,
// low word first, then the high word into the next register when enabled.
module multiplicador_secuencial #(
  parameter int ESCRIBIR_PARTE_ALTA = 1
) (
  input  logic        Reloj,
  input  logic        Reiniciar,
  input  logic        Iniciar,
  input  logic [15:0] OperandoA,
  input  logic [15:0] OperandoB,
  input  logic [2:0]  DireccionDestino,
  output logic [15:0] Salida,
  output logic        HabilitarEscritura,
  output logic [2:0]  DireccionEscritura,
  output logic        Ocupado,
  output logic        Listo,
  output logic        Desborde
);

  typedef enum logic [1:0] {
    REPOSO,
    CALCULO,
    ESCRIBIR_BAJO,
    ESCRIBIR_ALTO
  } estado_t;

  localparam bit ALTA = (ESCRIBIR_PARTE_ALTA != 0);

  estado_t     estado;
  logic [31:0] multiplicando;   // shifted left one place per step
  logic [15:0] multiplicador;   // shifted right one place per step
  logic [31:0] acumulador;
  logic [3:0]  contador;
  logic [2:0]  destino;
  logic [31:0] suma;

  // Partial product for the current multiplier bit. On the last step this
  // is already the full product, so the write outputs can be loaded from it
  // on the same edge that leaves CALCULO.
  always_comb begin
    suma = acumulador + (multiplicador[0] ? multiplicando : 32'd0);
  end

  // Control FSM with registered outputs; reset aborts anything in flight.
  always_ff @(posedge Reloj or negedge Reiniciar) begin
    if (!Reiniciar) begin
      estado             <= REPOSO;
      multiplicando      <= '0;
      multiplicador      <= '0;
      acumulador         <= '0;
      contador           <= '0;
      destino            <= '0;
      Salida             <= '0;
      HabilitarEscritura <= 1'b0;
      DireccionEscritura <= '0;
      Ocupado            <= 1'b0;
      Listo              <= 1'b0;
      Desborde           <= 1'b0;
    end else begin
      case (estado)
        REPOSO: begin
          if (Iniciar) begin
            multiplicando <= {16'd0, OperandoA};
            multiplicador <= OperandoB;
            destino       <= DireccionDestino;
            acumulador    <= '0;
            contador      <= '0;
            Desborde      <= 1'b0;
            Ocupado       <= 1'b1;
            estado        <= CALCULO;
          end
        end
        CALCULO: begin
          // Always 16 steps regardless of operand values.
          acumulador    <= suma;
          multiplicando <= multiplicando << 1;
          multiplicador <= multiplicador >> 1;
          contador      <= contador + 4'd1;
          if (contador == 4'd15) begin
            estado             <= ESCRIBIR_BAJO;
            HabilitarEscritura <= 1'b1;
            DireccionEscritura <= destino;
            Salida             <= suma[15:0];
            Desborde           <= |suma[31:16];
            // Low word is the final write when the high word is not stored.
            Listo              <= !ALTA;
          end
        end
        ESCRIBIR_BAJO: begin
          if (ALTA) begin
            estado             <= ESCRIBIR_ALTO;
            DireccionEscritura <= destino + 3'd1;  // 7 wraps to 0
            Salida             <= acumulador[31:16];
            Listo              <= 1'b1;
          end else begin
            estado             <= REPOSO;
            HabilitarEscritura <= 1'b0;
            DireccionEscritura <= '0;
            Salida             <= '0;
            Listo              <= 1'b0;
            Ocupado            <= 1'b0;
          end
        end
        ESCRIBIR_ALTO: begin
          estado             <= REPOSO;
          HabilitarEscritura <= 1'b0;
          DireccionEscritura <= '0;
          Salida             <= '0;
          Listo              <= 1'b0;
          Ocupado            <= 1'b0;
        end
        default: begin
          estado             <= REPOSO;
          HabilitarEscritura <= 1'b0;
          DireccionEscritura <= '0;
          Salida             <= '0;
          Listo              <= 1'b0;
          Ocupado            <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiplicador_secuencial.sv
// Bench for multiplicador_secuencial: one instance writing both words and one
// writing the low word only, checked cycle by cycle against a timeline model
// built from the product computed with plain arithmetic.
module tb_multiplicador_secuencial;

  logic        Reloj = 1'b0;
  logic        Reiniciar = 1'b0;
  logic        iniciar1 = 1'b0;
  logic        iniciar0 = 1'b0;
  logic [15:0] OperandoA = '0;
  logic [15:0] OperandoB = '0;
  logic [2:0]  DireccionDestino = '0;

  logic [15:0] salida1, salida0;
  logic        we1, we0, ocup1, ocup0, listo1, listo0, desb1, desb0;
  logic [2:0]  dir1, dir0;

  int checks = 0;
  int errors = 0;

  always #5 Reloj = ~Reloj;

  multiplicador_secuencial #(.ESCRIBIR_PARTE_ALTA(1)) dut_alta (
    .Reloj(Reloj), .Reiniciar(Reiniciar), .Iniciar(iniciar1),
    .OperandoA(OperandoA), .OperandoB(OperandoB), .DireccionDestino(DireccionDestino),
    .Salida(salida1), .HabilitarEscritura(we1), .DireccionEscritura(dir1),
    .Ocupado(ocup1), .Listo(listo1), .Desborde(desb1)
  );

  multiplicador_secuencial #(.ESCRIBIR_PARTE_ALTA(0)) dut_baja (
    .Reloj(Reloj), .Reiniciar(Reiniciar), .Iniciar(iniciar0),
    .OperandoA(OperandoA), .OperandoB(OperandoB), .DireccionDestino(DireccionDestino),
    .Salida(salida0), .HabilitarEscritura(we0), .DireccionEscritura(dir0),
    .Ocupado(ocup0), .Listo(listo0), .Desborde(desb0)
  );

  // Observed outputs packed as {we, addr, data, listo, ocupado, desborde}.
  logic [22:0] obs1, obs0;
  assign obs1 = {we1, dir1, salida1, listo1, ocup1, desb1};
  assign obs0 = {we0, dir0, salida0, listo0, ocup0, desb0};

  task automatic chk(input string tag, input logic [22:0] got, input logic [22:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (we,addr,data,listo,ocupado,desborde)", tag, got, exp);
    end
  endtask

  // Expected outputs k cycles after the start edge (k=0 is the cycle right
  // after the accepting edge). The low word is written 16 cycles later, the
  // high word one cycle after that when enabled.
  function automatic logic [22:0] esperado(input bit alta, input int k,
                                           input logic [15:0] a, input logic [15:0] b,
                                           input logic [2:0] d);
    logic [31:0] p;
    int ultimo;
    logic        we, li, oc, de;
    logic [2:0]  ad;
    logic [15:0] da;
    p      = 32'(a) * 32'(b);
    ultimo = alta ? 17 : 16;
    we = 0; ad = 0; da = 0;
    if (k == 16) begin
      we = 1; ad = d; da = p[15:0];
    end else if (alta && k == 17) begin
      we = 1; ad = 3'((int'(d) + 1) % 8); da = p[31:16];
    end
    li = (k == ultimo);
    oc = (k <= ultimo);
    de = (k >= 16) && (p[31:16] != 0);
    return {we, ad, da, li, oc, de};
  endfunction

  // Called just after the accepting edge; scrambles nothing itself, samples
  // 19 falling edges (through the first idle cycle) and ends on a falling edge.
  task automatic check_op(input string nombre, input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] d, input bit con_baja);
    for (int k = 0; k < 19; k++) begin
      @(negedge Reloj);
      chk($sformatf("%s_alta_k%0d", nombre, k), obs1, esperado(1'b1, k, a, b, d));
      if (con_baja)
        chk($sformatf("%s_baja_k%0d", nombre, k), obs0, esperado(1'b0, k, a, b, d));
    end
  endtask

  // Starts both instances at the next rising edge, then changes the inputs
  // so that only the latched copies can produce the right answer.
  task automatic run_op(input string nombre, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] d);
    OperandoA = a; OperandoB = b; DireccionDestino = d;
    iniciar1 = 1'b1; iniciar0 = 1'b1;
    @(posedge Reloj); #1;
    iniciar1 = 1'b0; iniciar0 = 1'b0;
    OperandoA = 16'($urandom); OperandoB = 16'($urandom); DireccionDestino = 3'($urandom);
    check_op(nombre, a, b, d, 1'b1);
  endtask

  initial begin
    logic [15:0] a2, b2;
    logic [2:0]  d2;

    // Reset state
    #2;
    chk("reset_alta", obs1, 23'd0);
    chk("reset_baja", obs0, 23'd0);
    @(negedge Reloj);
    Reiniciar = 1'b1;
    @(negedge Reloj);

    // Directed cases
    run_op("a3_b5", 16'h0003, 16'h0005, 3'd2);
    run_op("ffff_ffff", 16'hFFFF, 16'hFFFF, 3'd4);
    run_op("wrap_dest7", 16'h1234, 16'h0100, 3'd7);
    run_op("ovf_8000x4", 16'h8000, 16'h0004, 3'd1);
    run_op("zero_a", 16'h0000, 16'hBEEF, 3'd3);
    run_op("zero_b", 16'hCAFE, 16'h0000, 3'd6);

    // Randomized operations
    for (int i = 0; i < 10; i++)
      run_op($sformatf("rnd%0d", i), 16'($urandom), 16'($urandom), 3'($urandom));

    // Start held high: second operation accepted on the first idle edge
    a2 = 16'($urandom); b2 = 16'($urandom); d2 = 3'($urandom);
    OperandoA = 16'h00FF; OperandoB = 16'h0101; DireccionDestino = 3'd5;
    iniciar1 = 1'b1;
    @(posedge Reloj); #1;
    OperandoA = a2; OperandoB = b2; DireccionDestino = d2;
    check_op("hold_first", 16'h00FF, 16'h0101, 3'd5, 1'b0);
    @(posedge Reloj); #1;
    iniciar1 = 1'b0;
    OperandoA = 16'($urandom); OperandoB = 16'($urandom);
    check_op("hold_second", a2, b2, d2, 1'b0);

    // Reset in the middle of CALCULO
    OperandoA = 16'h7777; OperandoB = 16'h9999; DireccionDestino = 3'd0;
    iniciar1 = 1'b1; iniciar0 = 1'b1;
    @(posedge Reloj); #1;
    iniciar1 = 1'b0; iniciar0 = 1'b0;
    repeat (8) @(posedge Reloj);
    #2;
    Reiniciar = 1'b0;
    #1;
    chk("midreset_alta", obs1, 23'd0);
    chk("midreset_baja", obs0, 23'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge Reloj);
      chk($sformatf("inreset_alta_k%0d", k), obs1, 23'd0);
      chk($sformatf("inreset_baja_k%0d", k), obs0, 23'd0);
    end
    Reiniciar = 1'b1;
    // First edge after reset release must accept the start
    run_op("post_reset_2x3", 16'h0002, 16'h0003, 3'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Overall time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
